// File: rtl/collision_arbiter_if.sv
// Requester/checker bus for the collision arbiter.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface collision_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] req_x;
    logic [9*N_REQ-1:0]  req_y;
    logic [2*N_REQ-1:0]  req_dir;
    logic                chk_start;
    logic [9:0]          chk_x;
    logic [8:0]          chk_y;
    logic [1:0]          chk_dir;
    logic                chk_done;
    logic                chk_ok;
    logic [N_REQ-1:0]    done;
    logic                rsp_ok;
    logic                busy;
    logic                err_timeout;

    modport slave (
        input  req, req_x, req_y, req_dir, chk_done, chk_ok,
        output chk_start, chk_x, chk_y, chk_dir, done, rsp_ok, busy, err_timeout
    );

    modport master (
        output req, req_x, req_y, req_dir, chk_done, chk_ok,
        input  chk_start, chk_x, chk_y, chk_dir, done, rsp_ok, busy, err_timeout
    );
endinterface

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one collision checker among N_REQ requesters,
// with a per-transaction response timeout and a sticky timeout error flag.
module collision_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    collision_arbiter_if.slave  bus
);
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned DW = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [XW-1:0]    RST_X   = XW'(320);
    localparam logic [YW-1:0]    RST_Y   = YW'(146);
    localparam logic [CW-1:0]    CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [CW-1:0]   cnt;

    logic [N_REQ-1:0] elig;
    logic             grant_found;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;

    // Round-robin search from ptr; a requester being acknowledged this cycle is masked.
    always_comb begin
        elig        = bus.req & ~bus.done;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((32'(ptr) + 32'(k)) % 32'(N_REQ));
            if (!grant_found && elig[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            winner          <= '0;
            cnt             <= '0;
            bus.chk_start   <= 1'b0;
            bus.chk_x       <= RST_X;
            bus.chk_y       <= RST_Y;
            bus.chk_dir     <= '0;
            bus.done        <= '0;
            bus.rsp_ok      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.chk_start <= 1'b0;
            bus.done      <= '0;
            bus.rsp_ok    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        winner        <= grant_idx;
                        bus.chk_x     <= bus.req_x[32'(grant_idx)*XW +: XW];
                        bus.chk_y     <= bus.req_y[32'(grant_idx)*YW +: YW];
                        bus.chk_dir   <= bus.req_dir[32'(grant_idx)*DW +: DW];
                        ptr           <= IW'((32'(grant_idx) + 32'd1) % 32'(N_REQ));
                        bus.chk_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A checker result on the last allowed cycle beats the timeout.
                    if (bus.chk_done) begin
                        bus.done   <= ONE << winner;
                        bus.rsp_ok <= bus.chk_ok;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        bus.done        <= ONE << winner;
                        bus.rsp_ok      <= 1'b0;
                        bus.err_timeout <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: reset, single grant, fairness,
// timeout, timeout race, reset mid-transaction and self-masking.
module tb_collision_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    collision_arbiter_if #(.N_REQ(4)) bus ();

    collision_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [9:0] x, input logic [8:0] y, input logic [1:0] d);
        bus.req_x[i*10 +: 10] = x;
        bus.req_y[i*9 +: 9]   = y;
        bus.req_dir[i*2 +: 2] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.chk_done = 1'b0;
        bus.chk_ok = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.chk_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.chk_x !== 10'd320) begin errors++; $display("FAIL reset_chk_x: got %0d expected 320", bus.chk_x); end
        checks++; if (bus.chk_y !== 9'd146) begin errors++; $display("FAIL reset_chk_y: got %0d expected 146", bus.chk_y); end
        checks++; if (bus.chk_dir !== 2'b00) begin errors++; $display("FAIL reset_chk_dir: got %b expected 00", bus.chk_dir); end
        checks++; if ({bus.chk_start, bus.busy, bus.rsp_ok, bus.err_timeout} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got start/busy/rsp/err=%b expected 0000",
                               {bus.chk_start, bus.busy, bus.rsp_ok, bus.err_timeout}); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
    endtask

    task automatic test_single();
        do_reset();
        set_slot(0, 10'd320, 9'd146, 2'b10);
        bus.req = 4'b0001;
        tick();
        checks++; if (bus.chk_start !== 1'b1 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL single_issue: got start=%b busy=%b expected 1 1", bus.chk_start, bus.busy); end
        checks++; if ({bus.chk_x, bus.chk_y, bus.chk_dir} !== {10'd320, 9'd146, 2'b10}) begin errors++;
            $display("FAIL single_operands: got x=%0d y=%0d dir=%b expected 320 146 10", bus.chk_x, bus.chk_y, bus.chk_dir); end
        set_slot(0, 10'd5, 9'd7, 2'b01);
        tick();
        checks++; if (bus.chk_start !== 1'b0 || bus.chk_x !== 10'd320 || bus.chk_dir !== 2'b10) begin errors++;
            $display("FAIL single_hold: got start=%b x=%0d dir=%b expected 0 320 10", bus.chk_start, bus.chk_x, bus.chk_dir); end
        bus.chk_done = 1'b1;
        bus.chk_ok = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        bus.req = 4'b0000;
        checks++; if (bus.done !== 4'b0001 || bus.rsp_ok !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL single_done: got done=%b rsp=%b busy=%b expected 0001 1 0", bus.done, bus.rsp_ok, bus.busy); end
        tick();
        checks++; if (bus.done !== 4'b0000 || bus.rsp_ok !== 1'b0) begin errors++;
            $display("FAIL single_pulse_end: got done=%b rsp=%b expected 0000 0", bus.done, bus.rsp_ok); end
    endtask

    task automatic test_fairness();
        bit seen;
        int exp_idx;
        logic [3:0] exp_done;
        logic exp_ok;
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 10'(100 + i), 9'(10 + i), 2'(i));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx  = k % 4;
            exp_done = 4'b0001 << exp_idx;
            exp_ok   = k[0];
            wait_start(8, seen);
            checks++; if (!seen) begin errors++; $display("FAIL fair_start_%0d: got no chk_start expected one", k); end
            checks++; if (bus.chk_x !== 10'(100 + exp_idx)) begin errors++;
                $display("FAIL fair_grant_%0d: got x=%0d expected %0d", k, bus.chk_x, 100 + exp_idx); end
            tick();
            bus.chk_done = 1'b1;
            bus.chk_ok = exp_ok;
            tick();
            bus.chk_done = 1'b0;
            checks++; if (bus.done !== exp_done || bus.rsp_ok !== exp_ok) begin errors++;
                $display("FAIL fair_done_%0d: got done=%b rsp=%b expected %b %b", k, bus.done, bus.rsp_ok, exp_done, exp_ok); end
            bus.req[exp_idx] = 1'b0;
            tick();
            bus.req[exp_idx] = 1'b1;
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_timeout();
        bit seen;
        do_reset();
        set_slot(2, 10'd40, 9'd50, 2'b11);
        bus.req = 4'b0100;
        wait_start(4, seen);
        checks++; if (!seen || bus.chk_x !== 10'd40) begin errors++;
            $display("FAIL timeout_grant: got seen=%b x=%0d expected 1 40", seen, bus.chk_x); end
        tick();
        for (int i = 0; i < 14; i++) tick();
        checks++; if (bus.done !== 4'b0000 || bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL timeout_early: got done=%b err=%b busy=%b expected 0000 0 1", bus.done, bus.err_timeout, bus.busy); end
        tick();
        bus.req = 4'b0000;
        checks++; if (bus.done !== 4'b0100 || bus.rsp_ok !== 1'b0 || bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL timeout_fire: got done=%b rsp=%b err=%b busy=%b expected 0100 0 1 0",
                     bus.done, bus.rsp_ok, bus.err_timeout, bus.busy); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.err_timeout !== 1'b1) begin errors++;
            $display("FAIL timeout_sticky: got err=%b expected 1", bus.err_timeout); end
    endtask

    task automatic test_race();
        bit seen;
        do_reset();
        checks++; if (bus.err_timeout !== 1'b0) begin errors++;
            $display("FAIL race_err_cleared: got err=%b expected 0", bus.err_timeout); end
        bus.req = 4'b0010;
        wait_start(4, seen);
        tick();
        for (int i = 0; i < 14; i++) tick();
        bus.chk_done = 1'b1;
        bus.chk_ok = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        bus.req = 4'b0000;
        checks++; if (bus.done !== 4'b0010 || bus.rsp_ok !== 1'b1 || bus.err_timeout !== 1'b0) begin errors++;
            $display("FAIL race_done: got done=%b rsp=%b err=%b expected 0010 1 0", bus.done, bus.rsp_ok, bus.err_timeout); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 10'(200 + i), 9'(20 + i), 2'(i));
        bus.req = 4'b0010;
        wait_start(4, seen);
        tick();
        tick();
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 4'b0000 || bus.chk_x !== 10'd320) begin errors++;
            $display("FAIL midrst_state: got busy=%b done=%b x=%0d expected 0 0000 320", bus.busy, bus.done, bus.chk_x); end
        bus.chk_done = 1'b1;
        bus.chk_ok = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        checks++; if (bus.done !== 4'b0000 || bus.rsp_ok !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL midrst_late_done: got done=%b rsp=%b busy=%b expected 0000 0 0", bus.done, bus.rsp_ok, bus.busy); end
        bus.req = 4'b1001;
        tick();
        checks++; if (bus.chk_start !== 1'b1 || bus.chk_x !== 10'd200) begin errors++;
            $display("FAIL midrst_ptr: got start=%b x=%0d expected 1 200", bus.chk_start, bus.chk_x); end
        tick();
        bus.chk_done = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_self_mask();
        bit seen;
        do_reset();
        set_slot(1, 10'd77, 9'd88, 2'b01);
        bus.req = 4'b0010;
        wait_start(4, seen);
        tick();
        bus.chk_done = 1'b1;
        bus.chk_ok = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        checks++; if (bus.done !== 4'b0010) begin errors++;
            $display("FAIL mask_first_done: got done=%b expected 0010", bus.done); end
        tick();
        checks++; if (bus.chk_start !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL mask_gap: got start=%b busy=%b expected 0 0", bus.chk_start, bus.busy); end
        bus.chk_done = 1'b1;
        tick();
        checks++; if (bus.chk_start !== 1'b1 || bus.chk_x !== 10'd77) begin errors++;
            $display("FAIL mask_regrant: got start=%b x=%0d expected 1 77", bus.chk_start, bus.chk_x); end
        bus.chk_done = 1'b1;
        bus.chk_ok = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        bus.chk_ok = 1'b0;
        tick();
        checks++; if (bus.done !== 4'b0000) begin errors++;
            $display("FAIL mask_issue_ignored: got done=%b expected 0000", bus.done); end
        bus.chk_done = 1'b1;
        tick();
        bus.chk_done = 1'b0;
        bus.req = 4'b0000;
        checks++; if (bus.done !== 4'b0010 || bus.rsp_ok !== 1'b0) begin errors++;
            $display("FAIL mask_second_done: got done=%b rsp=%b expected 0010 0", bus.done, bus.rsp_ok); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_dir = '0;
        bus.chk_done = 1'b0;
        bus.chk_ok = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_race();
        test_reset_mid_wait();
        test_self_mask();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/collision_arbiter.md
COLLISION_ARBITER -- requirements
Module: collision_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (0 = Pac-Man turn check, 1 = Pac-Man line check, 2/3 = ghosts).
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before a forced blocked response; range 1..15.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high on rst.
REQ-004 Ports:
- clk  input  1: system clock.
- rst  input  1: synchronous active-high reset.
- req  input  N_REQ: per-requester level request, held until that requester's done.
- req_x  input  10*N_REQ: packed X position, slice i = [10i+9:10i].
- req_y  input  9*N_REQ: packed Y position, slice i = [9i+8:9i].
- req_dir  input  2*N_REQ: packed direction (00 up, 01 down, 10 left, 11 right).
- chk_start  output  1: one-cycle start pulse to the shared collision checker.
- chk_x  output  10: checker X operand.
- chk_y  output  9: checker Y operand.
- chk_dir  output  2: checker direction operand.
- chk_done  input  1: checker result-valid pulse.
- chk_ok  input  1: 1 = path free, valid with chk_done.
- done  output  N_REQ: one-hot, one-cycle completion pulse to the granted requester.
- rsp_ok  output  1: result for the requester pulsed on done; valid only while done != 0.
- busy  output  1: high in ISSUE and WAIT.
- err_timeout  output  1: sticky flag, set on any timeout.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE and WAIT; reset state IDLE.
REQ-006 IDLE arbitration:
- Eligible requesters are those with req high, excluding any requester whose done bit is high in the same cycle.
- The winner is chosen round-robin, starting the search at index ptr and wrapping modulo N_REQ.
REQ-007 On a win, the block SHALL register the winner index and its x/y/dir slices into chk_x/chk_y/chk_dir, set ptr = (winner+1) mod N_REQ, and go to ISSUE.
REQ-008 In IDLE with no eligible request, state, ptr and chk_* SHALL hold.
REQ-009 ISSUE SHALL last exactly one cycle, with chk_start=1, then go to WAIT; chk_start is 0 in every other state.
REQ-010 chk_x/chk_y/chk_dir SHALL be stable from ISSUE until the return to IDLE; input changes after the grant are ignored.
REQ-011 WAIT on chk_done=1:
- Next cycle: done[winner]=1 and rsp_ok=chk_ok (registered).
- State returns to IDLE in that same next cycle.
REQ-012 WAIT timeout counter:
- Cleared on entry to WAIT, incremented each WAIT cycle without chk_done.
- When the counter reaches TIMEOUT, the block SHALL pulse done[winner] with rsp_ok=0, set err_timeout, and return to IDLE.
REQ-013 chk_done arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal response, no error flag.
REQ-014 chk_done in IDLE or ISSUE SHALL be ignored.
REQ-015 A requester dropping req after its grant SHALL NOT abort the transaction; its done pulse is still issued.
REQ-016 Minimum latency from req rising (in IDLE) to done: 3 cycles when chk_done arrives the first WAIT cycle; at most one transaction is in flight.
REQ-017 done SHALL be one-hot or zero; rsp_ok SHALL be 0 whenever done == 0.

Reset
REQ-018 rst=1 SHALL, at the next clk edge, force IDLE with:
- ptr=0 and timeout counter=0.
- chk_start=0, done=0, rsp_ok=0, busy=0, err_timeout=0.
- chk_x=320, chk_y=146, chk_dir=00.
REQ-019 Reset mid-transaction SHALL abandon it with no done pulse; a chk_done arriving after reset SHALL be ignored.

Verification
REQ-020 Single request: req=0001, x=320, y=146, dir=10; chk_done=1, chk_ok=1 in the first WAIT cycle -> chk_start in cycle 1 with chk_x=320, chk_y=146, chk_dir=10; done=0001, rsp_ok=1 in cycle 3.
REQ-021 Fairness: req=1111 held, each done followed by a one-cycle req drop -> grant order 0,1,2,3,0; no requester granted twice in a row while others wait.
REQ-022 Timeout: grant requester 2, chk_done never asserted -> done=0100, rsp_ok=0, err_timeout=1 exactly 15 cycles after entering WAIT; err_timeout stays 1 until rst.
REQ-023 Race: chk_done=1, chk_ok=1 on the 15th WAIT cycle -> done with rsp_ok=1, err_timeout stays 0.
REQ-024 Reset mid-WAIT: rst=1 for one cycle, then chk_done=1 -> no done pulse; busy=0; the next request restarts arbitration from index 0.
REQ-025 Self-mask: only req[1] held continuously -> after done[1], at least one IDLE cycle with no grant before requester 1 is granted again.
